// File: rtl/rgb_led_bank.sv
// Bank of RGB indicator LEDs: per-LED off/solid/counted-blink FSM on a shared blink prescaler.
// Optional macro LED_PWM_EN adds a duty input that gates every colour drive with a shared PWM.
module rgb_led_bank #(
  parameter int unsigned NUM_LEDS    = 3,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned BLINK_HALF  = 25000000,
  parameter int unsigned BLINK_CNT_W = 4,
  parameter int unsigned PWM_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0]       duty,
`endif
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [IDX_W-1:0]       cmd_led,
  input  logic [2:0]             cmd_color,
  input  logic [BLINK_CNT_W-1:0] cmd_blinks,
  output logic                   cmd_err,
  output logic [NUM_LEDS-1:0]    led_r,
  output logic [NUM_LEDS-1:0]    led_g,
  output logic [NUM_LEDS-1:0]    led_b,
  output logic [NUM_LEDS-1:0]    busy
);

  localparam int unsigned      PreW   = $clog2(BLINK_HALF);
  localparam logic [PreW-1:0]  PreMax = PreW'(BLINK_HALF - 1);
  localparam logic [IDX_W-1:0] MaxIdx = IDX_W'(NUM_LEDS);

  typedef enum logic [1:0] {StOff, StSolid, StBlinkOn, StBlinkOff} state_e;

  logic                   ready_q, pend_q, err_q;
  logic [IDX_W-1:0]       led_q;
  logic [2:0]             color_q;
  logic [BLINK_CNT_W-1:0] blinks_q;
  logic [PreW-1:0]        pre_q;
  logic                   tick, accept, idx_ok, pwm_on;
  logic [2:0]             color_sel;
  logic [NUM_LEDS-1:0]    hit;

  state_e                 state_q [NUM_LEDS];
  logic [2:0]             rgb_q   [NUM_LEDS];  // resolved one-hot {r,b,g}
  logic [BLINK_CNT_W-1:0] rem_q   [NUM_LEDS];

  assign accept    = cmd_valid & ready_q;
  assign tick      = (pre_q == PreMax);
  assign idx_ok    = (led_q != '0) && (led_q <= MaxIdx);
  assign cmd_ready = ready_q;
  assign cmd_err   = err_q;

  always_comb begin
    color_sel = 3'b000;
    if (color_q[2])      color_sel = 3'b100;
    else if (color_q[1]) color_sel = 3'b010;
    else if (color_q[0]) color_sel = 3'b001;
  end

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      hit[i] = pend_q && idx_ok && (led_q == IDX_W'(i + 1));
    end
  end

  // Command is latched on accept and applied one edge later; ready drops for that one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q  <= 1'b0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      led_q    <= '0;
      color_q  <= '0;
      blinks_q <= '0;
      pre_q    <= '0;
    end else begin
      ready_q <= ~accept;
      pend_q  <= accept;
      err_q   <= pend_q & ~idx_ok;
      if (accept) begin
        led_q    <= cmd_led;
        color_q  <= cmd_color;
        blinks_q <= cmd_blinks;
      end
      pre_q <= tick ? '0 : pre_q + PreW'(1);
    end
  end

  // An apply to an LED takes precedence over a coincident tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        state_q[i] <= StOff;
        rgb_q[i]   <= '0;
        rem_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (hit[i]) begin
          rgb_q[i] <= color_sel;
          rem_q[i] <= blinks_q;
          if (color_sel == 3'b000)   state_q[i] <= StOff;
          else if (blinks_q == '0)   state_q[i] <= StSolid;
          else                       state_q[i] <= StBlinkOn;
        end else if (tick) begin
          case (state_q[i])
            StBlinkOn:  state_q[i] <= StBlinkOff;
            StBlinkOff: begin
              rem_q[i]   <= rem_q[i] - BLINK_CNT_W'(1);
              state_q[i] <= (rem_q[i] == BLINK_CNT_W'(1)) ? StSolid : StBlinkOn;
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + PWM_W'(1);
  end

  assign pwm_on = (pwm_cnt < duty);
`else
  assign pwm_on = (PWM_W != 0);
`endif

  always_comb begin
    led_r = '0;
    led_g = '0;
    led_b = '0;
    busy  = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if ((state_q[i] == StSolid) || (state_q[i] == StBlinkOn)) begin
        led_r[i] = rgb_q[i][2] & pwm_on;
        led_b[i] = rgb_q[i][1] & pwm_on;
        led_g[i] = rgb_q[i][0] & pwm_on;
      end
      busy[i] = (state_q[i] == StBlinkOn) || (state_q[i] == StBlinkOff);
    end
  end

endmodule

// File: tb/tb_rgb_led_bank.sv
// Directed bench for rgb_led_bank (NUM_LEDS=3, IDX_W=3, BLINK_HALF=4) with an output scoreboard.
module tb_rgb_led_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_led;
  logic [2:0] cmd_color;
  logic [3:0] cmd_blinks;
  logic       cmd_err;
  logic [2:0] led_r, led_g, led_b, busy;
`ifdef LED_PWM_EN
  logic [7:0] duty;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [1:0] m_pre;
  logic [7:0] m_pwm;

  typedef struct {
    string      tag;
    logic [2:0] r, g, b, bsy;
    logic       err;
  } exp_t;
  exp_t sb[$];

  rgb_led_bank #(
    .NUM_LEDS   (3),
    .IDX_W      (3),
    .BLINK_HALF (4),
    .BLINK_CNT_W(4),
    .PWM_W      (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef LED_PWM_EN
    .duty      (duty),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_led   (cmd_led),
    .cmd_color (cmd_color),
    .cmd_blinks(cmd_blinks),
    .cmd_err   (cmd_err),
    .led_r     (led_r),
    .led_g     (led_g),
    .led_b     (led_b),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Shared blink timebase and PWM counter as described for the block.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_pre <= 2'd0;
      m_pwm <= 8'd0;
    end else begin
      m_pre <= (m_pre == 2'd3) ? 2'd0 : m_pre + 2'd1;
      m_pwm <= m_pwm + 8'd1;
    end
  end

  function automatic logic [2:0] gate();
`ifdef LED_PWM_EN
    return {3{m_pwm < duty}};
`else
    return 3'b111;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic [2:0] r, input logic [2:0] g,
                      input logic [2:0] b, input logic [2:0] bsy, input logic err);
    exp_t e;
    e.tag = tag; e.r = r; e.g = g; e.b = b; e.bsy = bsy; e.err = err;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    n_vec++;
    assert (sb.size() != 0) else begin
      n_err++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".r"},    led_r,   e.r & gate());
    chk({e.tag, ".g"},    led_g,   e.g & gate());
    chk({e.tag, ".b"},    led_b,   e.b & gate());
    chk({e.tag, ".busy"}, busy,    e.bsy);
    chk({e.tag, ".err"},  cmd_err, e.err);
  endtask

  // Called at a negedge; returns at the negedge after the apply edge.
  task automatic send(input string tag, input logic [2:0] led, input logic [2:0] color,
                      input logic [3:0] blinks, input logic [2:0] er, input logic [2:0] eg,
                      input logic [2:0] eb, input logic [2:0] ebsy, input logic eerr);
    chk({tag, ".rdy_pre"}, cmd_ready, 1);
    cmd_led = led; cmd_color = color; cmd_blinks = blinks; cmd_valid = 1'b1;
    push(tag, er, eg, eb, ebsy, eerr);
    @(negedge clk);
    chk({tag, ".rdy_low"}, cmd_ready, 0);
    // Held valid with different fields while not ready: must be ignored.
    cmd_led = 3'd1; cmd_color = 3'b100; cmd_blinks = 4'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    pop_check();
    chk({tag, ".rdy_back"}, cmd_ready, 1);
  endtask

  task automatic step_tick(input string tag);
    int n;
    n = 0;
    while (m_pre != 2'd3 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".tick_bound"}, (n < 8), 1);
    @(negedge clk);
    pop_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_led = 3'd2; cmd_color = 3'b111; cmd_blinks = 4'd0;
`ifdef LED_PWM_EN
    duty = 8'd255;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.r", led_r, 0);
    chk("rst.g", led_g, 0);
    chk("rst.b", led_b, 0);
    chk("rst.busy", busy, 0);
    chk("rst.err", cmd_err, 0);
    chk("rst.ready", cmd_ready, 0);
    rst_n = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst.ready_rel", cmd_ready, 1);

    send("prio", 3'd2, 3'b111, 4'd0, 3'b010, 3'b000, 3'b000, 3'b000, 1'b0);
    send("blue", 3'd3, 3'b011, 4'd0, 3'b010, 3'b000, 3'b100, 3'b000, 1'b0);

    send("blink", 3'd1, 3'b001, 4'd2, 3'b010, 3'b001, 3'b100, 3'b001, 1'b0);
    push("blink.t1", 3'b010, 3'b000, 3'b100, 3'b001, 1'b0); step_tick("blink.t1");
    push("blink.t2", 3'b010, 3'b001, 3'b100, 3'b001, 1'b0); step_tick("blink.t2");
    push("blink.t3", 3'b010, 3'b000, 3'b100, 3'b001, 1'b0); step_tick("blink.t3");
    push("blink.t4", 3'b010, 3'b001, 3'b100, 3'b000, 1'b0); step_tick("blink.t4");
    push("blink.t5", 3'b010, 3'b001, 3'b100, 3'b000, 1'b0); step_tick("blink.t5");

    send("ovr.start", 3'd1, 3'b001, 4'd3, 3'b010, 3'b001, 3'b100, 3'b001, 1'b0);
    push("ovr.off_ph", 3'b010, 3'b000, 3'b100, 3'b001, 1'b0); step_tick("ovr.off_ph");
    send("ovr.kill", 3'd1, 3'b000, 4'd5, 3'b010, 3'b000, 3'b100, 3'b000, 1'b0);

    send("bad0", 3'd0, 3'b100, 4'd0, 3'b010, 3'b000, 3'b100, 3'b000, 1'b1);
    @(negedge clk);
    chk("bad0.err_clr", cmd_err, 0);
    send("bad4", 3'd4, 3'b100, 4'd0, 3'b010, 3'b000, 3'b100, 3'b000, 1'b1);
    @(negedge clk);
    chk("bad4.err_clr", cmd_err, 0);
    send("bad5", 3'd5, 3'b001, 4'd1, 3'b010, 3'b000, 3'b100, 3'b000, 1'b1);
    @(negedge clk);
    chk("bad5.err_clr", cmd_err, 0);

    send("rstblink", 3'd3, 3'b100, 4'd5, 3'b110, 3'b000, 3'b000, 3'b100, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2.r", led_r, 0);
    chk("rst2.b", led_b, 0);
    chk("rst2.busy", busy, 0);
    chk("rst2.ready", cmd_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2.ready_rel", cmd_ready, 1);
    chk("rst2.r_after", led_r, 0);

`ifdef LED_PWM_EN
    send("pwm.setup", 3'd2, 3'b100, 4'd0, 3'b010, 3'b000, 3'b000, 3'b000, 1'b0);
    duty = 8'd64;
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (led_r[1]) cnt++;
    end
    chk("pwm.d64", cnt, 64);
    duty = 8'd0;
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (led_r[1]) cnt++;
    end
    chk("pwm.d0", cnt, 0);
    chk("pwm.busy", busy, 0);
`else
    cnt = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
